bit_count_scheduler: RTL
========================

// Module: bit_count_scheduler
// PURPOSE
//  Round-robin scheduler sharing one bit-counter unit among N_REQ requesters.
//  Grants one request at a time and latches its operand. Sequences the counter's start/done handshake
//  (load, run, release), then returns the popcount result with a one-cycle ack to the winner.
//  Sits between client blocks and the single bit-counter controller+datapath instance.
// PARAMETERS
//  N_REQ          4              number of requesters (>=2)
//  A_WIDTH        8              operand width
//  RET_WIDTH      4              result width; must satisfy 2**RET_WIDTH > A_WIDTH
//  TIMEOUT_CYCLES 2*A_WIDTH+4    watchdog limit, used only with BCS_TIMEOUT_EN
//  (localparam ID_W = $clog2(N_REQ))
// PORTS
//  clock       in   1               single clock, posedge
//  reset       in   1               synchronous, active-high
//  req         in   N_REQ           per-requester request; held high until own ack
//  req_data    in   N_REQ*A_WIDTH   operands; slice i = req_data[i*A_WIDTH +: A_WIDTH]
//  ack         out  N_REQ           one-hot one-cycle pulse: result valid for that requester
//  result      out  RET_WIDTH       popcount, valid while ack!=0 and held until next ack
//  result_id   out  ID_W            index of the requester being acked
//  busy        out  1               high in every state except S_IDLE
//  cnt_s       out  1               start to bit counter
//  cnt_a       out  A_WIDTH         operand to bit counter
//  cnt_done    in   1               counter done; held high while cnt_s high
//  cnt_result  in   RET_WIDTH       counter result, valid while cnt_done
//  timeout     out  1               (BCS_TIMEOUT_EN only) pulses with ack on abort
// BEHAVIOUR
//  Reset: state=S_IDLE, rr_ptr=0, cnt_s=0, cnt_a=0, ack=0, result=0, result_id=0, busy=0,
//   timeout=0. Reset mid-operation abandons the job without an ack. The counter sees cnt_s=0
//   and returns to its idle state. The requester keeps req high and is re-granted.
//  Arbitration in S_IDLE: scan from rr_ptr upward, modulo N_REQ, for the first req bit set.
//   On grant, latch grant id and req_data slice into op_reg, then go to S_LOAD.
//   rr_ptr <= (id+1) mod N_REQ on grant.
//   No req set: stay in S_IDLE.
//  FSM:
//   S_IDLE    cnt_s=0; grant -> S_LOAD
//   S_LOAD    cnt_s=0, cnt_a=op_reg for exactly 1 cycle (the counter loads A while s is low) -> S_RUN
//   S_RUN     cnt_s=1, cnt_a=op_reg; cnt_done=1 -> capture cnt_result into result, -> S_REL
//   S_REL     cnt_s=0; wait for cnt_done=0 -> S_ACK
//   S_ACK     ack[id]=1, result_id=id for 1 cycle -> S_IDLE
//  cnt_a holds op_reg from S_LOAD through S_REL. Changes to req_data after grant are ignored.
//  Minimum latency from grant cycle to ack: 4 + counter run cycles.
//  Throughput: at most one job in flight. S_ACK returns to S_IDLE, so back-to-back grants are
//   separated by 1 idle cycle.
//  A requester must drop req in the cycle after its ack. If req is still high then, it is a new
//   request and is scheduled after the other pending requesters (fairness).
//  Simultaneous requests: rotating priority. No requester waits more than N_REQ-1 jobs.
//  req deasserted after grant: the job still completes and ack is still pulsed.
//  cnt_done high in S_LOAD (stale): ignored. Only S_RUN samples cnt_done.
//  Operand 0: the counter finishes immediately. result=0 is acked normally.
//  Operand all-ones: result=A_WIDTH with no truncation (see RET_WIDTH rule).
// CONFIGURATION
//  `BCS_TIMEOUT_EN defined:
//   - A watchdog counts cycles in S_RUN and S_REL.
//   - On reaching TIMEOUT_CYCLES: force cnt_s=0, set result=0, go to S_ACK, and pulse timeout
//     together with ack.
//   - Watchdog clears on every entry to S_LOAD.
//  `BCS_TIMEOUT_EN undefined: no watchdog logic; the timeout port is absent; S_RUN and S_REL
//   wait indefinitely.
// TESTING
//  1 reset, no req for 10 cycles -> busy=0, cnt_s=0, ack=0 throughout
//  2 req=0001, data0=8'hB5 -> cnt_a=8'hB5 with cnt_s=0 for 1 cycle, then cnt_s=1;
//    ack=0001, result=5, result_id=0
//  3 req=1111 held, data i=8'hFF,8'h00,8'h0F,8'h81 -> acks in order 0,1,2,3;
//    results 8,0,4,2; 1 idle cycle between jobs
//  4 after test 3 (rr_ptr=0), req=1010 together -> grant 1 then 3;
//    re-raise req1 with req3 pending -> 3 is served before 1
//  5 reset asserted during S_RUN -> next cycle cnt_s=0, state idle, rr_ptr=0, no ack;
//    held req re-granted and completes correctly
//  6 BCS_TIMEOUT_EN, counter model never raises cnt_done -> after TIMEOUT_CYCLES
//    ack and timeout pulse together, result=0; next request served normally

Source files
------------

// File: rtl/bit_count_scheduler.sv
// bit_count_scheduler: round-robin front end that shares a single bit-counter
// unit among N_REQ requesters. It grants one job at a time, runs the counter's
// load/run/release handshake and returns the popcount with a one-cycle ack.
// Optional watchdog: define BCS_TIMEOUT_EN to abort a job whose counter never
// completes; the timeout output port only exists in that build.
module bit_count_scheduler #(
  parameter int N_REQ          = 4,
  parameter int A_WIDTH        = 8,
  parameter int RET_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 2*A_WIDTH+4,
  localparam int ID_W          = $clog2(N_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*A_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]         ack,
  output logic [RET_WIDTH-1:0]     result,
  output logic [ID_W-1:0]          result_id,
  output logic                     busy,
  output logic                     cnt_s,
  output logic [A_WIDTH-1:0]       cnt_a,
  input  logic                     cnt_done,
  input  logic [RET_WIDTH-1:0]     cnt_result
`ifdef BCS_TIMEOUT_EN
  ,
  output logic                     timeout
`endif
);

  // The result port must be wide enough to hold a full-ones popcount.
  if ((2**RET_WIDTH) <= A_WIDTH || TIMEOUT_CYCLES < 1 || N_REQ < 2) begin : g_bad_params
    $error("bit_count_scheduler: invalid parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_REL  = 3'd3,
    S_ACK  = 3'd4
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic [A_WIDTH-1:0] op_reg;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_next;
  logic [ID_W:0]      scan_sum;
  logic               wd_expired;

  localparam logic [ID_W:0] N_REQ_W = (ID_W+1)'(N_REQ);

  // Rotating-priority search starting at rr_ptr; the first set req bit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_next  = '0;
    scan_sum    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (scan_sum >= N_REQ_W) scan_sum = scan_sum - N_REQ_W;
      if (!grant_valid && req[scan_sum[ID_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_next  = scan_sum[ID_W-1:0];
      end
    end
  end

`ifdef BCS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);
  logic [WD_W-1:0] wd_count;
  logic            timed_out;

  assign wd_expired = ((state == S_RUN) || (state == S_REL)) &&
                      (wd_count == WD_W'(TIMEOUT_CYCLES-1));

  // Watchdog counts cycles spent waiting on the counter and restarts with each job.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_count  <= '0;
      timed_out <= 1'b0;
    end else if (state == S_LOAD) begin
      wd_count  <= '0;
      timed_out <= 1'b0;
    end else if (wd_expired) begin
      timed_out <= 1'b1;
    end else if ((state == S_RUN) || (state == S_REL)) begin
      wd_count <= wd_count + 1'b1;
    end
  end

  assign timeout = (state == S_ACK) && timed_out;
`else
  assign wd_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; the watchdog abort overrides the counter handshake.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (grant_valid) next_state = S_LOAD;
      S_LOAD: next_state = S_RUN;
      S_RUN:  if (wd_expired) next_state = S_ACK;
              else if (cnt_done) next_state = S_REL;
      S_REL:  if (wd_expired || !cnt_done) next_state = S_ACK;
      S_ACK:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state and the latched job.
  always_comb begin
    busy  = (state != S_IDLE);
    cnt_s = (state == S_RUN);
    cnt_a = '0;
    ack   = '0;
    if ((state == S_LOAD) || (state == S_RUN) || (state == S_REL)) cnt_a = op_reg;
    if (state == S_ACK) ack[grant_id] = 1'b1;
  end

  // Job bookkeeping: grant latch, pointer rotation, result capture and ack id.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      op_reg    <= '0;
      result    <= '0;
      result_id <= '0;
    end else begin
      if ((state == S_IDLE) && grant_valid) begin
        grant_id <= grant_next;
        op_reg   <= req_data[grant_next*A_WIDTH +: A_WIDTH];
        rr_ptr   <= (grant_next == ID_W'(N_REQ-1)) ? '0 : grant_next + 1'b1;
      end
      if (wd_expired) begin
        result <= '0;
      end else if ((state == S_RUN) && cnt_done) begin
        result <= cnt_result;
      end
      if ((next_state == S_ACK) && (state != S_ACK)) begin
        result_id <= grant_id;
      end
    end
  end

endmodule
